score_text_formatter: RTL
=========================

# score_text_formatter

Producer side of the on-screen text buffer. The block converts binary game statistics (score, level) into the packed ASCII character array consumed by the HUD text renderer. Conversion is serial double-dabble, one bit per clock. The output array is updated atomically, so the renderer never displays a half-converted frame. It sits between the game-logic score/level registers and the text renderer's `text` input.

## Interface
- `COLS`, 16: characters per line. Must be ≥ 12. `LINES` is fixed at 2.
- `SCORE_W`, 20: score input width.
- `LEVEL_W`, 8: level input width.
- `clk` in 1: system clock. All state is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `update` in 1: request a new conversion. Sampled each edge.
- `score` in SCORE_W: binary score. Sampled only on a start edge.
- `level` in LEVEL_W: binary level. Sampled only on a start edge.
- `busy` out 1: high while in any state other than IDLE.
- `done` out 1: one-cycle pulse in the cycle after `text` changes.
- `text` out 8·COLS·2: packed characters. Character index `i = row·COLS + col` occupies bits `[8i+7:8i]`, so index 0 is the LSB byte.

## Operation
- Line 0 layout:
  - cols 0–4: "SCORE".
  - cols 5 to COLS−7: space (0x20).
  - last 6 cols: score as 6 decimal digits, zero-padded, MSD first.
- Line 1 layout:
  - cols 0–4: "LEVEL".
  - cols 5 to COLS−3: space.
  - last 2 cols: level as 2 digits. A leading zero is blanked to space.
- Digits are encoded as 0x30 + d.
- Saturation is applied when the inputs are latched:
  - score > 999999 latches as 999999.
  - level > 99 latches as 99.
- FSM states are IDLE, SCORE, LEVEL, COMMIT.
  - IDLE: when `update` is high, latch the saturated score/level, clear the BCD accumulator, load the bit counter, and go to SCORE.
  - SCORE: 20 iterations. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts {bcd[23:0], bin} left by 1. After the 20th iteration, store the 6 score digits, load level left-aligned into the shifter, clear the BCD, and go to LEVEL.
  - LEVEL: 8 iterations using the same shifter. Then go to COMMIT.
  - COMMIT: write the full `text` image in one edge and assert `done` next cycle. Then go to SCORE if `pending` is set (relatch inputs, clear `pending`), otherwise go to IDLE.
- `update` asserted in any non-IDLE state sets `pending`. Multiple requests collapse into one.
- `text` holds its value between commits.
- Reset values:
  - state IDLE; `busy` 0; `done` 0; `pending` 0.
  - `text` = the image for score 0, level 0: "SCORE…000000" on line 0 and "LEVEL… 0" on line 1.

## Timing
- Latency: `update` sampled at edge E0 → SCORE shifts on E1–E20 → LEVEL shifts on E21–E28 → `text` written at E29. `done` is high for the cycle following E29.
- `busy` rises after E0. It falls after E29 only if no restart is pending.
- A pending restart latches inputs at E29. The next `text` write is at E58.
- Asserting `reset` mid-conversion immediately restores the reset image and IDLE. The partial result is discarded and `done` is not pulsed.
- `text` changes only at a COMMIT edge or on reset. No intermediate values are visible.
- Arithmetic: the BCD accumulator is 24 bits. The add-3 step is per nibble with no carry between nibbles. The shifter is SCORE_W bits wide.

## Structure
- Shared package `hud_pkg`:
  - `ASCII_SPACE`, `ASCII_ZERO`.
  - Label byte constants for "SCORE" and "LEVEL".
  - `fmt_state_t` enum.
  - Score/level saturation limits.
- Sub-module `bcd_add3` (combinational): 24-bit per-nibble adjust. Instantiated once inside the shift step.
- The text image is assembled by a function in the package. It is used for both the reset value and COMMIT.

## Test plan
- Reset, then read `text` → bytes 10–15 = "000000"; byte 30 = 0x20; byte 31 = 0x30; `busy` = 0.
- score = 123456, level = 7, pulse `update` → after 29 cycles, bytes 10–15 = "123456", bytes 30–31 = " 7", `done` pulses once.
- score = 1,000,000, level = 250 → "999999", "99".
- At cycle 10 of a conversion of score = 5, change score to 42 and pulse `update` → first commit shows "000005". Second commit at +58 shows "000042". `pending` clears.
- Assert `reset` at cycle 15 of a conversion → `text` returns to the reset image, `busy` = 0, no `done`.
- Compare the full 32-byte image for level = 10 and score = 99 against the package function → line 1 ends "10"; all label bytes and padding bytes match exactly.

Source files
------------

// File: rtl/score_text_formatter_pkg.sv
// Shared definitions for the HUD score/level text producer.
//   - ASCII constants and label byte strings ("SCORE", "LEVEL")
//   - fmt_state_t: conversion FSM states
//   - saturation limits for score and level
//   - build_text(): assembles the two-line character image from BCD digits.
//     It is used both for the reset image and for the COMMIT write, so the
//     two can never disagree on layout.
package hud_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // String literals pack the first character in the most significant byte.
    localparam logic [39:0] LABEL_SCORE = "SCORE";
    localparam logic [39:0] LABEL_LEVEL = "LEVEL";

    localparam int SCORE_MAX = 999999;
    localparam int LEVEL_MAX = 99;

    // build_text returns an image sized for the widest supported line; the
    // caller keeps the low 16*cols bits.
    localparam int MAX_COLS   = 64;
    localparam int TEXT_MAX_W = 8 * MAX_COLS * 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCORE  = 2'd1,
        ST_LEVEL  = 2'd2,
        ST_COMMIT = 2'd3
    } fmt_state_t;

    // Character index i = row*cols + col lives in bits [8i+7:8i].
    // score_bcd holds 6 digits with the most significant digit in [23:20];
    // level_bcd holds tens in [7:4] and ones in [3:0].
    function automatic logic [TEXT_MAX_W-1:0] build_text(
        input logic [23:0] score_bcd,
        input logic [7:0]  level_bcd,
        input int          cols
    );
        logic [TEXT_MAX_W-1:0] img;
        logic [7:0]            ch;
        int                    col;
        img = '0;
        for (int i = 0; i < 2 * MAX_COLS; i++) begin
            ch  = 8'h00;
            col = 0;
            if (i < cols) begin
                col = i;
                if (col < 5)
                    ch = LABEL_SCORE[8*(4-col) +: 8];
                else if (col >= cols - 6)
                    ch = ASCII_ZERO + {4'h0, score_bcd[4*(cols-1-col) +: 4]};
                else
                    ch = ASCII_SPACE;
            end else if (i < 2 * cols) begin
                col = i - cols;
                if (col < 5)
                    ch = LABEL_LEVEL[8*(4-col) +: 8];
                else if (col == cols - 2)
                    // Leading zero of the level is blanked.
                    ch = (level_bcd[7:4] == 4'd0) ? ASCII_SPACE
                                                  : ASCII_ZERO + {4'h0, level_bcd[7:4]};
                else if (col == cols - 1)
                    ch = ASCII_ZERO + {4'h0, level_bcd[3:0]};
                else
                    ch = ASCII_SPACE;
            end
            img[8*i +: 8] = ch;
        end
        return img;
    endfunction

endpackage

// File: rtl/score_text_formatter_bcd_add3.sv
// bcd_add3: combinational double-dabble adjust for a 6-digit BCD word.
// Every nibble >= 5 gets +3; nibbles are independent (no carry between them).
//   i_bcd  [23:0]  BCD accumulator before the shift
//   o_bcd  [23:0]  adjusted accumulator, ready to be shifted left by one
module bcd_add3 (
    input  logic [23:0] i_bcd,
    output logic [23:0] o_bcd
);

    for (genvar n = 0; n < 6; n++) begin : g_nib
        assign o_bcd[4*n +: 4] = (i_bcd[4*n +: 4] >= 4'd5) ? i_bcd[4*n +: 4] + 4'd3
                                                             : i_bcd[4*n +: 4];
    end

endmodule

// File: rtl/score_text_formatter.sv
// score_text_formatter: converts binary score/level into the packed ASCII
// image read by the HUD text renderer. Serial double-dabble, one bit per clock:
// 20 score bits, then 8 level bits, then a single-edge commit of the whole image.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   update  in   conversion request, sampled every edge
//   score   in   binary score (latched, saturated to 999999, at start)
//   level   in   binary level (latched, saturated to 99, at start)
//   busy    out  high whenever the FSM is not IDLE
//   done    out  one-cycle pulse in the cycle after text is written
//   text    out  2 lines x COLS characters, char i at bits [8i+7:8i]
//
// Handshake: update is a level request, no ready. In IDLE it starts a
// conversion on the sampling edge; while busy it is remembered in a single
// pending flag and serviced straight from COMMIT. text only changes on the
// COMMIT edge (or reset), and done marks that change one cycle later.
module score_text_formatter
    import hud_pkg::*;
#(
    parameter int COLS    = 16,
    parameter int SCORE_W = 20,
    parameter int LEVEL_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  update,
    input  logic [SCORE_W-1:0]    score,
    input  logic [LEVEL_W-1:0]    level,
    output logic                  busy,
    output logic                  done,
    output logic [8*COLS*2-1:0]   text
);

    localparam int TEXT_W = 8 * COLS * 2;
    localparam int CNT_W  = $clog2(SCORE_W);

    localparam logic [SCORE_W-1:0] SCORE_LIM = SCORE_W'(SCORE_MAX);
    localparam logic [LEVEL_W-1:0] LEVEL_LIM = LEVEL_W'(LEVEL_MAX);
    localparam logic [TEXT_W-1:0]  RESET_IMG = TEXT_W'(build_text(24'h0, 8'h0, COLS));

    fmt_state_t             r_state;
    fmt_state_t             w_next;
    logic                   r_pending;
    logic                   r_done;
    logic [CNT_W-1:0]       r_cnt;
    logic [SCORE_W-1:0]     r_shift;
    logic [23:0]            r_bcd;
    logic [23:0]            r_score_digits;
    logic [LEVEL_W-1:0]     r_level_lat;
    logic [TEXT_W-1:0]      r_text;

    logic [SCORE_W-1:0]     w_score_sat;
    logic [LEVEL_W-1:0]     w_level_sat;
    logic [23:0]            w_adj;
    logic [24+SCORE_W-1:0]  w_cat;
    logic [23:0]            w_bcd_next;
    logic [SCORE_W-1:0]     w_shift_next;
    logic                   w_restart;
    logic [TEXT_W-1:0]      w_image;

    assign w_score_sat = (score > SCORE_LIM) ? SCORE_LIM : score;
    assign w_level_sat = (level > LEVEL_LIM) ? LEVEL_LIM : level;

    bcd_add3 u_add3 (
        .i_bcd (r_bcd),
        .o_bcd (w_adj)
    );

    // One double-dabble step: {bcd, bin} <<= 1 after the nibble adjust.
    assign w_cat        = {w_adj, r_shift} << 1;
    assign w_bcd_next   = w_cat[24+SCORE_W-1:SCORE_W];
    assign w_shift_next = w_cat[SCORE_W-1:0];

    // A request arriving on the COMMIT edge itself is folded into the restart.
    assign w_restart = r_pending | update;

    assign w_image = TEXT_W'(build_text(r_score_digits, r_bcd[7:0], COLS));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (update)          w_next = ST_SCORE;
            ST_SCORE:  if (r_cnt == '0)     w_next = ST_LEVEL;
            ST_LEVEL:  if (r_cnt == '0)     w_next = ST_COMMIT;
            ST_COMMIT: w_next = w_restart ? ST_SCORE : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending      <= 1'b0;
            r_done         <= 1'b0;
            r_cnt          <= '0;
            r_shift        <= '0;
            r_bcd          <= '0;
            r_score_digits <= '0;
            r_level_lat    <= '0;
            r_text         <= RESET_IMG;
        end else begin
            r_done <= (r_state == ST_COMMIT);

            if (r_state == ST_COMMIT)
                r_pending <= 1'b0;
            else if (r_state != ST_IDLE && update)
                r_pending <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (update) begin
                        r_shift     <= w_score_sat;
                        r_level_lat <= w_level_sat;
                        r_bcd       <= '0;
                        r_cnt       <= CNT_W'(SCORE_W - 1);
                    end
                end
                ST_SCORE: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        // Last score bit: park the digits and start on level.
                        r_score_digits <= w_bcd_next;
                        r_bcd          <= '0;
                        r_shift        <= {r_level_lat, {(SCORE_W-LEVEL_W){1'b0}}};
                        r_cnt          <= CNT_W'(LEVEL_W - 1);
                    end else begin
                        r_bcd   <= w_bcd_next;
                        r_shift <= w_shift_next;
                    end
                end
                ST_LEVEL: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt - CNT_W'(1);
                end
                ST_COMMIT: begin
                    r_text <= w_image;
                    if (w_restart) begin
                        r_shift     <= w_score_sat;
                        r_level_lat <= w_level_sat;
                        r_bcd       <= '0;
                        r_cnt       <= CNT_W'(SCORE_W - 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign text = r_text;

endmodule
